lsu_bus_arbiter: RTL
====================

LSU_BUS_ARBITER -- requirements
Module: lsu_bus_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive beats granted to one requester while the other is requesting (legal 1..15).
REQ-002 The block SHALL have i_clk, input, 1, the clock; i_reset, input, 1, the reset (synchronous, active-high).
REQ-003 The block SHALL have, for each requester n in {0,1}: i_mn_req (input, 1, request), i_mn_we (input, 1, write), i_mn_addr (input, 32, byte address), i_mn_wdata (input, 32, store data) and i_mn_op (input, 2: 0x word, 10 half, 11 byte).
REQ-004 The block SHALL have, for each n: o_mn_gnt (output, 1, beat accepted), o_mn_rvalid (output, 1, read data valid) and o_mn_rdata (output, 32, read data).
REQ-005 The block SHALL have, on the LSU side: o_s_addr (output, 32), o_s_wdata (output, 32), o_s_op (output, 2), o_s_wren (output, 1) and i_s_rdata (input, 32, combinational load data).

Function
REQ-006 A beat SHALL occur in any cycle where o_mn_gnt and i_mn_req are both 1; at most one o_mn_gnt SHALL be 1 per cycle.
REQ-007 The FSM SHALL have states IDLE, OWN0 and OWN1, plus a 1-bit last-owner pointer and a 4-bit beat counter.
REQ-008 Grant SHALL be combinational from state, requests and counter, giving zero cycles from request to grant.
REQ-009 In IDLE with exactly one requester, that requester SHALL be granted; with both requesting, the requester not equal to last-owner SHALL be granted (round-robin).
REQ-010 In OWNn with i_mn_req=1 and counter < BURST_MAX-1, or with the other requester idle, master n SHALL keep the grant and the counter SHALL increment, saturating at 15.
REQ-011 In OWNn with counter = BURST_MAX-1 and the other requester requesting, the other requester SHALL be granted in that same cycle, the state SHALL move to OWN(other) and the counter SHALL become 0.
REQ-012 In OWNn with i_mn_req=0, the other requester SHALL be granted if it is requesting (next state OWN(other)); otherwise the next state SHALL be IDLE.
REQ-013 On every state change into OWNn, last-owner SHALL be set to n.
REQ-014 During a beat, o_s_addr, o_s_wdata and o_s_op SHALL equal the granted requester's inputs, and o_s_wren SHALL equal its i_mn_we.
REQ-015 Outside a beat, o_s_wren SHALL be 0 and o_s_addr, o_s_wdata and o_s_op SHALL be 0.
REQ-016 A read beat (we=0) SHALL register i_s_rdata into o_mn_rdata and assert o_mn_rvalid for exactly one cycle, one cycle after the beat.
REQ-017 o_mn_rdata SHALL hold its value until the next read response to requester n.
REQ-018 A write beat SHALL produce no rvalid.
REQ-019 Back-to-back reads by alternating requesters SHALL each return data to the correct requester with no loss.

Reset
REQ-020 On i_reset, the FSM SHALL go to IDLE, last-owner SHALL be set to 1 (requester 0 wins the first tie) and the counter SHALL be cleared to 0.
REQ-021 On i_reset, o_m0_rvalid, o_m1_rvalid, o_m0_rdata and o_m1_rdata SHALL be cleared to 0.
REQ-022 While i_reset=1, both o_mn_gnt and o_s_wren SHALL be 0.
REQ-023 A read response pending when reset asserts SHALL be discarded.

Configuration
REQ-024 With ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and preempt requester 1 at the next beat boundary; BURST_MAX and last-owner SHALL be ignored, and requester 1 is granted only when i_m0_req=0.
REQ-025 With ARB_FIXED_PRIO_EN undefined, the round-robin and burst-limit behaviour of REQ-009 to REQ-012 SHALL apply.

Verification
REQ-026 After reset, drive m0 and m1 requests together with reads of 0x404 and 0x408 -> m0 is granted first, m1 the next cycle, and each rvalid returns one cycle after its beat.
REQ-027 Hold m0 requesting continuously with m1 requesting, BURST_MAX=4 -> m0 gets 4 beats, then m1 is granted on beat 5.
REQ-028 m1 writes 0xDEADBEEF to 0x10000000 with op=00 -> o_s_wren=1 for one cycle, o_s_addr=0x10000000, and no rvalid.
REQ-029 m0 issues a read, then i_reset is asserted in the following cycle -> o_m0_rvalid stays 0 and o_m0_rdata=0.
REQ-030 With ARB_FIXED_PRIO_EN defined and m0 requesting continuously -> m1 is never granted over 20 cycles.

Source files
------------

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: two-requester arbiter in front of a single LSU port.
// Grants are combinational (zero-cycle request-to-grant). Read data is
// captured from the LSU at the beat and returned one cycle later.
// In the default build, ties are broken round-robin and a requester's burst
// is limited to BURST_MAX beats while the other requester waits.
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 strictly
// higher priority. BURST_MAX and last-owner are then ignored.
//
// state | meaning
// IDLE  | no owner; the next requester (round-robin on a tie) gets the bus
// OWN0  | requester 0 received the most recent beat
// OWN1  | requester 1 received the most recent beat
module lsu_bus_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [1:0]  i_m0_op,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [1:0]  i_m1_op,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,

    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [1:0]  o_s_op,
    output logic        o_s_wren,
    input  logic [31:0] i_s_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter value at which the owner must yield if the other side waits.
    localparam logic [3:0] CNT_LIMIT = 4'(BURST_MAX - 1);

    state_t      state;
    logic        last_owner;
    logic [3:0]  beat_cnt;
    logic [3:0]  beat_cnt_inc;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0_q;
    logic        rvalid1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    assign beat_cnt_inc = (beat_cnt == 4'hF) ? 4'hF : beat_cnt + 4'd1;

    // Grant decision; grant only ever asserts together with the request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_reset) begin
`ifdef ARB_FIXED_PRIO_EN
            gnt0 = i_m0_req;
            gnt1 = i_m1_req & ~i_m0_req;
`else
            case (state)
                OWN0: begin
                    if (i_m0_req && (beat_cnt < CNT_LIMIT || !i_m1_req))
                        gnt0 = 1'b1;
                    else if (i_m1_req)
                        gnt1 = 1'b1;
                end
                OWN1: begin
                    if (i_m1_req && (beat_cnt < CNT_LIMIT || !i_m0_req))
                        gnt1 = 1'b1;
                    else if (i_m0_req)
                        gnt0 = 1'b1;
                end
                default: begin
                    if (i_m0_req && i_m1_req) begin
                        gnt0 = last_owner;
                        gnt1 = ~last_owner;
                    end else begin
                        gnt0 = i_m0_req;
                        gnt1 = i_m1_req;
                    end
                end
            endcase
`endif
        end
    end

    // Ownership follows whoever got this cycle's beat; the counter restarts
    // whenever ownership changes hands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= 4'd0;
        end else if (gnt0) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            beat_cnt   <= (state == OWN0) ? beat_cnt_inc : 4'd0;
        end else if (gnt1) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            beat_cnt   <= (state == OWN1) ? beat_cnt_inc : 4'd0;
        end else begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
        end
    end

    // LSU-side mux: granted requester's fields during a beat, zero otherwise.
    always_comb begin
        o_s_addr  = 32'd0;
        o_s_wdata = 32'd0;
        o_s_op    = 2'd0;
        o_s_wren  = 1'b0;
        if (gnt0) begin
            o_s_addr  = i_m0_addr;
            o_s_wdata = i_m0_wdata;
            o_s_op    = i_m0_op;
            o_s_wren  = i_m0_we;
        end else if (gnt1) begin
            o_s_addr  = i_m1_addr;
            o_s_wdata = i_m1_wdata;
            o_s_op    = i_m1_op;
            o_s_wren  = i_m1_we;
        end
    end

    // Capture load data at a read beat and return it to that requester next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            rvalid0_q <= gnt0 & ~i_m0_we;
            rvalid1_q <= gnt1 & ~i_m1_we;
            if (gnt0 && !i_m0_we)
                rdata0_q <= i_s_rdata;
            if (gnt1 && !i_m1_we)
                rdata1_q <= i_s_rdata;
        end
    end

    // A response already captured when reset arrives is suppressed immediately
    // rather than leaking out during the reset cycle.
    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;
    assign o_m0_rvalid = rvalid0_q & ~i_reset;
    assign o_m1_rvalid = rvalid1_q & ~i_reset;
    assign o_m0_rdata  = i_reset ? 32'd0 : rdata0_q;
    assign o_m1_rdata  = i_reset ? 32'd0 : rdata1_q;

endmodule
